// File: rtl/mips_defs.sv
// Shared opcode/funct constants, instruction-class flags and control-field
// encodings for the multi-cycle MIPS controller.
package mips_defs;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_OR  = 2'd2,
    ALU_LUI = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    NPC_PC4    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_REG    = 2'd3
  } npc_sel_t;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } regdst_t;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_DM  = 2'd1,
    WD_PC4 = 2'd2
  } wd_sel_t;

  // One-hot instruction class; all-zero means undecodable.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
  } inst_t;

endpackage

// File: rtl/mc_decode.sv
// Maps opcode/funct onto a one-hot instruction class plus an illegal flag.
module mc_decode
  import mips_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output inst_t      inst,
  output logic       illegal
);

  always_comb begin
    inst = '0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADDU: inst.addu = 1'b1;
          FN_SUBU: inst.subu = 1'b1;
          FN_JR:   inst.jr   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  inst.ori = 1'b1;
      OP_LUI:  inst.lui = 1'b1;
      OP_LW:   inst.lw  = 1'b1;
      OP_SW:   inst.sw  = 1'b1;
      OP_BEQ:  inst.beq = 1'b1;
      OP_J:    inst.j   = 1'b1;
      OP_JAL:  inst.jal = 1'b1;
      default: ;
    endcase
    illegal = ~|inst;
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXE/MEM/WB sequencing with
// combinational control outputs and a retired-instruction counter.
module mc_ctrl
  import mips_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             im_ready,
  input  logic             dm_ready,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             ir_we,
  output logic             reg_we,
  output logic [1:0]       regdst,
  output logic [1:0]       wd_sel,
  output logic             alusrc,
  output logic [1:0]       alu_op,
  output logic             extop,
  output logic             dm_re,
  output logic             dm_we,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  inst_t    inst;
  logic     dec_illegal;
  state_t   cur, nxt;
  logic     retire;
  logic     pc_we_c, ir_we_c, reg_we_c, dm_re_c, dm_we_c;
  npc_sel_t npc_c;
  regdst_t  dst_c;
  wd_sel_t  wd_c;
  alu_op_t  alu_c;

  mc_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .inst    (inst),
    .illegal (dec_illegal)
  );

  always_comb begin
    nxt      = cur;
    retire   = 1'b0;
    pc_we_c  = 1'b0;
    ir_we_c  = 1'b0;
    reg_we_c = 1'b0;
    dm_re_c  = 1'b0;
    dm_we_c  = 1'b0;
    npc_c    = NPC_PC4;
    dst_c    = DST_RT;
    wd_c     = WD_ALU;
    alu_c    = ALU_ADD;
    alusrc   = 1'b0;
    extop    = 1'b0;
    illegal  = 1'b0;

    // MEM keeps the EXE operand/ALU setup so the address stays stable.
    if (cur == S_EXE || cur == S_MEM) begin
      if (inst.subu || inst.beq) alu_c = ALU_SUB;
      if (inst.ori)              alu_c = ALU_OR;
      if (inst.lui)              alu_c = ALU_LUI;
      alusrc = inst.ori | inst.lui | inst.lw | inst.sw;
      extop  = inst.lw | inst.sw | inst.beq;
    end

    case (cur)
      S_FETCH: begin
        if (im_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        nxt = S_EXE;
        if (inst.j || inst.jal) begin
          pc_we_c = 1'b1;
          npc_c   = NPC_JUMP;
          nxt     = S_FETCH;
          retire  = 1'b1;
        end
        if (inst.jal) begin
          reg_we_c = 1'b1;
          dst_c    = DST_RA;
          wd_c     = WD_PC4;
        end
        if (inst.jr) begin
          pc_we_c = 1'b1;
          npc_c   = NPC_REG;
          nxt     = S_FETCH;
          retire  = 1'b1;
        end
        if (dec_illegal) begin
          illegal = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_EXE: begin
        if (inst.beq) begin
          pc_we_c = zero;
          npc_c   = NPC_BRANCH;
          nxt     = S_FETCH;
          retire  = 1'b1;
        end else if (inst.lw || inst.sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        dm_re_c = inst.lw;
        dm_we_c = inst.sw;
        if (dm_ready) begin
          nxt    = inst.lw ? S_WB : S_FETCH;
          retire = ~inst.lw;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        if (inst.addu || inst.subu) dst_c = DST_RD;
        if (inst.lw)                wd_c  = WD_DM;
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Enables are forced low while reset is held, even though FETCH may see im_ready.
  assign pc_we   = pc_we_c  & rst_n;
  assign ir_we   = ir_we_c  & rst_n;
  assign reg_we  = reg_we_c & rst_n;
  assign dm_re   = dm_re_c  & rst_n;
  assign dm_we   = dm_we_c  & rst_n;
  assign npc_sel = npc_c;
  assign regdst  = dst_c;
  assign wd_sel  = wd_c;
  assign alu_op  = alu_c;
  assign state   = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= S_FETCH;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-class phase paths and control tables
// as the reference, with directed and randomized instruction streams.
module tb_mc_ctrl;

  localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LUI = 3, C_LW = 4;
  localparam int C_SW = 5, C_BEQ = 6, C_J = 7, C_JAL = 8, C_JR = 9, C_ILL = 10;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] regdst;
    logic [1:0] wd_sel;
    logic       alusrc;
    logic [1:0] alu_op;
    logic       extop;
    logic       dm_re;
    logic       dm_we;
    logic       illegal;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        zero, im_ready, dm_ready;
  logic        pc_we, ir_we, reg_we, alusrc, extop, dm_re, dm_we, illegal;
  logic [1:0]  npc_sel, regdst, wd_sel, alu_op;
  logic [2:0]  state;
  logic [31:0] retired;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_retired = 0;
  string       cls_name [11] = '{"addu", "subu", "ori", "lui", "lw", "sw",
                                 "beq", "j", "jal", "jr", "illegal"};

  mc_ctrl #(.CNT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .funct    (funct),
    .zero     (zero),
    .im_ready (im_ready),
    .dm_ready (dm_ready),
    .pc_we    (pc_we),
    .npc_sel  (npc_sel),
    .ir_we    (ir_we),
    .reg_we   (reg_we),
    .regdst   (regdst),
    .wd_sel   (wd_sel),
    .alusrc   (alusrc),
    .alu_op   (alu_op),
    .extop    (extop),
    .dm_re    (dm_re),
    .dm_we    (dm_we),
    .illegal  (illegal),
    .state    (state),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  // Expected control word for one cycle of a given phase of an instruction.
  function automatic ctrl_t exp_ctrl(input int ph, input int cls, input logic z, input logic rdy);
    ctrl_t c;
    c = '0;
    case (ph)
      0: if (rdy) begin c.ir_we = 1'b1; c.pc_we = 1'b1; end
      1: begin
        if (cls == C_J)   begin c.pc_we = 1'b1; c.npc_sel = 2'd2; end
        if (cls == C_JAL) begin
          c.pc_we = 1'b1; c.npc_sel = 2'd2; c.reg_we = 1'b1; c.regdst = 2'd2; c.wd_sel = 2'd2;
        end
        if (cls == C_JR)  begin c.pc_we = 1'b1; c.npc_sel = 2'd3; end
        if (cls == C_ILL) c.illegal = 1'b1;
      end
      2, 3: begin
        case (cls)
          C_SUBU: c.alu_op = 2'd1;
          C_ORI:  begin c.alusrc = 1'b1; c.alu_op = 2'd2; end
          C_LUI:  begin c.alusrc = 1'b1; c.alu_op = 2'd3; end
          C_LW, C_SW: begin c.alusrc = 1'b1; c.extop = 1'b1; end
          C_BEQ:  begin
            c.alu_op = 2'd1; c.extop = 1'b1;
            if (ph == 2) begin c.pc_we = z; c.npc_sel = 2'd1; end
          end
          default: ;
        endcase
        if (ph == 3 && cls == C_LW) c.dm_re = 1'b1;
        if (ph == 3 && cls == C_SW) c.dm_we = 1'b1;
      end
      4: begin
        c.reg_we = 1'b1;
        if (cls == C_ADDU || cls == C_SUBU) c.regdst = 2'd1;
        if (cls == C_LW) c.wd_sel = 2'd1;
      end
      default: ;
    endcase
    return c;
  endfunction

  task automatic encode(input int cls, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (cls)
      C_ADDU: begin op = 6'h00; fn = 6'h21; end
      C_SUBU: begin op = 6'h00; fn = 6'h23; end
      C_JR:   begin op = 6'h00; fn = 6'h08; end
      C_ORI:  op = 6'h0D;
      C_LUI:  op = 6'h0F;
      C_LW:   op = 6'h23;
      C_SW:   op = 6'h2B;
      C_BEQ:  op = 6'h04;
      C_J:    op = 6'h02;
      C_JAL:  op = 6'h03;
      default: begin
        case ($urandom_range(0, 3))
          0: op = 6'h3F;
          1: op = 6'h01;
          2: op = 6'h08;
          default: begin op = 6'h00; fn = 6'h20; end
        endcase
      end
    endcase
  endtask

  task automatic checkOutput(input string tag, input ctrl_t exp, input logic [2:0] exp_state);
    ctrl_t obs;
    obs = {pc_we, npc_sel, ir_we, reg_we, regdst, wd_sel, alusrc, alu_op,
           extop, dm_re, dm_we, illegal};
    checks++;
    assert (state === exp_state) else begin
      failures++;
      $error("[TB] FAIL %s state got=%0d want=%0d", tag, state, exp_state);
    end
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s ctrl got=%h want=%h", tag, obs, exp);
    end
    checks++;
    assert (retired === model_retired) else begin
      failures++;
      $error("[TB] FAIL %s retired got=%0d want=%0d", tag, retired, model_retired);
    end
  endtask

  // Runs one instruction from FETCH; imw/dmw are wait cycles before ready rises.
  task automatic applyStimulus(input int cls, input logic z, input int imw, input int dmw);
    logic [5:0] op, fn;
    int         path[$];
    int         waits;
    logic       rdy;
    encode(cls, op, fn);
    opcode = op;
    funct  = fn;
    zero   = z;
    case (cls)
      C_LW:                        path = '{0, 1, 2, 3, 4};
      C_SW:                        path = '{0, 1, 2, 3};
      C_BEQ:                       path = '{0, 1, 2};
      C_J, C_JAL, C_JR, C_ILL:     path = '{0, 1};
      default:                     path = '{0, 1, 2, 4};
    endcase
    foreach (path[i]) begin
      waits = (path[i] == 0) ? imw : ((path[i] == 3) ? dmw : 0);
      for (int w = 0; w <= waits; w++) begin
        rdy      = (w == waits);
        im_ready = (path[i] == 0) ? rdy : 1'($urandom_range(0, 1));
        dm_ready = (path[i] == 3) ? rdy : 1'($urandom_range(0, 1));
        @(negedge clk);
        checkOutput($sformatf("%s_ph%0d_w%0d", cls_name[cls], path[i], w),
                    exp_ctrl(path[i], cls, z, rdy), 3'(path[i]));
        @(posedge clk);
        #1;
      end
    end
    if (cls != C_ILL) model_retired++;
  endtask

  initial begin
    rst_n    = 1'b0;
    opcode   = 6'h00;
    funct    = 6'h00;
    zero     = 1'b0;
    im_ready = 1'b1;
    dm_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_hold", '0, 3'd0);
    rst_n = 1'b1;

    applyStimulus(C_LW, 1'b0, 0, 0);
    applyStimulus(C_ORI, 1'b0, 0, 0);
    applyStimulus(C_LUI, 1'b1, 0, 0);
    applyStimulus(C_BEQ, 1'b0, 0, 0);
    applyStimulus(C_BEQ, 1'b1, 0, 0);
    applyStimulus(C_JAL, 1'b0, 0, 0);
    applyStimulus(C_JR, 1'b0, 0, 0);
    applyStimulus(C_J, 1'b1, 1, 0);
    applyStimulus(C_ADDU, 1'b1, 0, 0);
    applyStimulus(C_SUBU, 1'b0, 0, 0);
    applyStimulus(C_ILL, 1'b0, 0, 0);
    applyStimulus(C_SW, 1'b0, 0, 3);
    applyStimulus(C_LW, 1'b1, 2, 2);

    for (int n = 0; n < 60; n++)
      applyStimulus($urandom_range(0, 10), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), $urandom_range(0, 3));

    // Abandon an sw stalled in MEM by asserting reset between edges.
    opcode   = 6'h2B;
    funct    = 6'($urandom);
    zero     = 1'b0;
    im_ready = 1'b1;
    dm_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("sw_stall_mem", exp_ctrl(3, C_SW, 1'b0, 1'b0), 3'd3);
    #1;
    rst_n = 1'b0;
    model_retired = 0;
    #1;
    checkOutput("reset_mid_mem", '0, 3'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(C_ADDU, 1'b0, 2, 0);
    applyStimulus(C_SW, 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
